// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit.
//   - 3-bit operation select encodings
//   - output buffer occupancy states
package logic_gate_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_RED_OR = 3'd6;
  localparam logic [2:0] OP_PASS_A = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation core.
//   a, b : operands (WIDTH bits)
//   op   : operation select (logic_gate_pkg OP_* encodings)
//   y    : result (WIDTH bits); reduce-OR lands in y[0], upper bits zero
module logic_op_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XNOR:   y = ~(a ^ b);
      OP_RED_OR: y[0] = |a;
      OP_PASS_A: y = a;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Logic gate unit: valid/ready wrapped bitwise ALU with a 2-entry output
// buffer and a saturating count of accepted operand sets.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake for {a, b, op}
//   a, b, op          : operands and operation select
//   out_valid/out_ready : output handshake for y
//   y                 : head result, 0 when out_valid is 0
//   op_count          : accepted operand sets, saturating
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  buf_state_e       r_state;
  logic [WIDTH-1:0] r_head;   // oldest result, drives y; kept 0 when empty
  logic [WIDTH-1:0] r_tail;   // second result, only meaningful in FULL
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_res;
  logic             w_push;
  logic             w_pop;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (w_res)
  );

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_head      <= '0;
      r_tail      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_push && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        ST_EMPTY: begin
          // in_ready is 0 straight out of reset; EMPTY always re-arms it.
          r_in_ready <= 1'b1;
          if (w_push) begin
            r_head      <= w_res;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_tail     <= w_res;
              r_in_ready <= 1'b0;
              r_state    <= ST_FULL;
            end
            2'b01: begin
              r_head      <= '0;
              r_out_valid <= 1'b0;
              r_state     <= ST_EMPTY;
            end
            2'b11: r_head <= w_res;  // old head leaves, new one replaces it
            default: ;
          endcase
        end
        ST_FULL: begin
          // in_ready is 0 here, so only a pop can happen.
          if (w_pop) begin
            r_head     <= r_tail;
            r_tail     <= '0;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_head      <= '0;
          r_tail      <= '0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_head;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  y;
  logic [CW-1:0] op_count;

  int n_cmp = 0;
  int n_err = 0;

  // Model: results queue with capacity 2, registered ready flag, counter.
  logic [W-1:0] mq[$];
  logic         m_rdy = 1'b0;
  int           m_cnt = 0;

  logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] f_op(input logic [W-1:0] fa, fb, input logic [2:0] fop);
    logic [W-1:0] r;
    case (fop)
      3'd0: r = fa & fb;
      3'd1: r = fa | fb;
      3'd2: r = fa ^ fb;
      3'd3: r = ~(fa & fb);
      3'd4: r = ~(fa | fb);
      3'd5: r = ~(fa ^ fb);
      3'd6: r = (fa != 0) ? W'(1) : W'(0);
      default: r = fa;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on every rising edge.
  always @(posedge clk) begin
    logic push, pop;
    if (rst) begin
      mq.delete();
      m_rdy = 1'b0;
      m_cnt = 0;
    end else begin
      push = in_valid && m_rdy;
      pop  = (mq.size() > 0) && out_ready;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(f_op(a, b, op));
        if (m_cnt < CMAX) m_cnt++;
      end
      m_rdy = (mq.size() < 2);
    end
  end

  // Compare process: every cycle, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    chk("mdl_in_ready", 32'(in_ready), 32'(m_rdy));
    chk("mdl_out_valid", 32'(out_valid), (mq.size() > 0) ? 32'd1 : 32'd0);
    chk("mdl_y", 32'(y), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk("mdl_op_count", 32'(op_count), 32'(m_cnt));
  end

  // One clock: drive at falling edge, return 2 units after the rising edge.
  task automatic cyc(input logic r, input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                     input logic [2:0] iop, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [7:0] exp29 [8];
  logic [23:0] pat_iv, pat_or;

  initial begin
    exp29[0] = 8'h42; exp29[1] = 8'hDB; exp29[2] = 8'h99; exp29[3] = 8'hBD;
    exp29[4] = 8'h24; exp29[5] = 8'h66; exp29[6] = 8'h01; exp29[7] = 8'hC3;

    do_reset();

    // Single OR, 1-cycle latency.
    cyc(1'b0, 1'b1, 8'hA0, 8'h0F, 3'd1, 1'b1);
    chk("or_valid", 32'(out_valid), 32'd1);
    chk("or_y", 32'(y), 32'hAF);
    chk("or_count", 32'(op_count), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("or_drained", 32'(out_valid), 32'd0);

    // All eight ops back to back.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'hC3, 8'h5A, 3'(i), 1'b1);
      chk($sformatf("op%0d_y", i), 32'(y), 32'(exp29[i]));
    end
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("ops_count", 32'(op_count), 32'd8);

    // Backpressure: third push refused until a slot frees.
    do_reset();
    cyc(1'b0, 1'b1, 8'h01, 8'h00, 3'd7, 1'b0);
    chk("bp1_ready", 32'(in_ready), 32'd1);
    chk("bp1_y", 32'(y), 32'h01);
    cyc(1'b0, 1'b1, 8'h02, 8'h00, 3'd7, 1'b0);
    chk("bp2_ready", 32'(in_ready), 32'd0);
    chk("bp2_y", 32'(y), 32'h01);
    cyc(1'b0, 1'b1, 8'h03, 8'h00, 3'd7, 1'b0);
    chk("bp3_y_stable", 32'(y), 32'h01);
    chk("bp3_count", 32'(op_count), 32'd2);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("bp4_y", 32'(y), 32'h02);
    chk("bp4_ready", 32'(in_ready), 32'd1);
    cyc(1'b0, 1'b1, 8'h03, 8'h00, 3'd7, 1'b1);
    chk("bp5_y", 32'(y), 32'h03);
    chk("bp5_count", 32'(op_count), 32'd3);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("bp6_empty", 32'(out_valid), 32'd0);

    // Streaming: push and pop every cycle, buffer stays at one entry.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 8'(i), 8'h55, 3'd2, 1'b1);
      chk($sformatf("st%0d_y", i), 32'(y), 32'(8'(i) ^ 8'h55));
      chk($sformatf("st%0d_ready", i), 32'(in_ready), 32'd1);
    end
    chk("st_count", 32'(op_count), 32'd10);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("st_empty", 32'(out_valid), 32'd0);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'(i), 8'h00, 3'd7, 1'b1);
    chk("sat_count", 32'(op_count), 32'd15);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Reset while FULL drops both results.
    do_reset();
    cyc(1'b0, 1'b1, 8'h11, 8'h00, 3'd7, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 8'h00, 3'd7, 1'b0);
    chk("full_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("rf_valid", 32'(out_valid), 32'd0);
    chk("rf_y", 32'(y), 32'd0);
    chk("rf_count", 32'(op_count), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("rf_rel_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("rf_no_stale", 32'(out_valid), 32'd0);
    end

    // Mixed traffic with stalls; checked by the model each cycle.
    pat_iv = 24'b1101_1110_0111_1011_1100_1111;
    pat_or = 24'b0110_0011_1100_1010_1111_0001;
    for (int i = 0; i < 24; i++)
      cyc(1'b0, pat_iv[i], 8'($urandom), 8'($urandom), 3'(i), pat_or[i]);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("mix_empty", 32'(out_valid), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the accepted-operation counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  operand set {a, b, op} is presented.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an operand set this cycle.
REQ-007 The block SHALL have port a  input  WIDTH  operand A.
REQ-008 The block SHALL have port b  input  WIDTH  operand B.
REQ-009 The block SHALL have port op  input  3  operation select, encoded per REQ-013.
REQ-010 The block SHALL have port out_valid  output  1  y holds a valid result.
REQ-011 The block SHALL have port out_ready  input  1  downstream consumes y this cycle.
REQ-012 The block SHALL have port y  output  WIDTH  result; port op_count  output  CNT_W  number of accepted operand sets.

Function
REQ-013 The op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 reduce-OR of a (placed in y[0], upper bits 0), 7 pass a.
REQ-014 All bitwise ops SHALL be bit-for-bit logical, never arithmetic; OR of 1 and 1 is 1 with no carry.
REQ-015 A transfer on the input side SHALL occur when in_valid and in_ready are both 1 at a rising edge; on the output side when out_valid and out_ready are both 1.
REQ-016 The result SHALL be computed at acceptance and stored in a 2-entry output buffer with states EMPTY, ONE, FULL.
REQ-017 in_ready SHALL be a registered function of state only: 1 in EMPTY and ONE, 0 in FULL and during reset.
REQ-018 Latency SHALL be 1 cycle: an input accepted at edge k into EMPTY makes out_valid 1 with the result after edge k.
REQ-019 State transitions SHALL be as follows: EMPTY+push -> ONE; ONE+push-only -> FULL; ONE+pop-only -> EMPTY; ONE+push+pop -> ONE; FULL+pop -> ONE; any other combination holds the current state.
REQ-020 Results SHALL leave in acceptance order; a result SHALL never be dropped or duplicated.
REQ-021 y and out_valid SHALL remain stable while out_valid is 1 and out_ready is 0.
REQ-022 op_count SHALL increment by 1 on each input transfer and saturate at 2^CNT_W-1, with no wrap.
REQ-023 y SHALL be 0 whenever out_valid is 0.

Reset
REQ-024 While rst is 1 at an edge, the state SHALL become EMPTY and outputs SHALL be in_ready=0, out_valid=0, y=0, op_count=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered results; in_ready SHALL return to 1 on the first edge after rst deasserts.

Structure
REQ-026 The op encodings (3-bit constants) and the buffer state enumeration SHALL be defined in shared package logic_gate_pkg.
REQ-027 The combinational operation SHALL be isolated in one sub-module, logic_op_core (a, b, op -> y), instantiated once.

Verification
REQ-028 WIDTH=8, op=1, a=8'hA0, b=8'h0F, out_ready=1 -> y=8'hAF exactly 1 cycle after acceptance; op_count=1.
REQ-029 Ops 0..7 with a=8'hC3, b=8'h5A -> y = 42, DB, 99, BD, 24, 66, 01, C3 respectively, in order.
REQ-030 out_ready=0 with 3 pushes attempted -> the first 2 are accepted and in_ready=0 after the 2nd; raising out_ready then delivers both results in order, and the 3rd push is accepted afterward.
REQ-031 Continuous push and pop with in_valid=1 and out_ready=1 for 10 cycles -> state stays ONE, 10 results, op_count=10.
REQ-032 CNT_W=4 with 20 accepts -> op_count saturates at 15.
REQ-033 rst pulsed while FULL -> out_valid=0, y=0, op_count=0; in_ready=1 one cycle after release; no stale result emitted.
